vx_mem_responder: RTL and testbench
===================================

Name: vx_mem_responder

Overview:
- Memory-side responder for the Vortex external memory request/response interface.
- Sits on the far side of the vx_mem_req_* / vx_mem_rsp_* bus driven by the Vortex top level in the AHB-attached GPU wrapper.
- Accepts line-granular read/write requests into an on-chip byte-enabled line store.
- Returns read data with fixed programmable latency through an in-order response FIFO, with credit-based backpressure.

Parameters:
- DATA_WIDTH, 512, line width in bits; byteen width is DATA_WIDTH/8.
- ADDR_WIDTH, 26, line address width of mem_req_addr.
- TAG_WIDTH, 16, width of mem_req_tag and mem_rsp_tag.
- MEM_ADDR_BITS, 10, log2 of lines stored; index = mem_req_addr[MEM_ADDR_BITS-1:0], upper bits ignored (aliasing).
- LATENCY, 4, cycles from read acceptance to earliest mem_rsp_valid; legal range 1..16.
- RSP_DEPTH, 8, maximum outstanding reads (pipeline plus FIFO); power of two, at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- mem_req_valid  in  1  request valid
- mem_req_rw  in  1  1 = write, 0 = read
- mem_req_byteen  in  DATA_WIDTH/8  write byte enables
- mem_req_addr  in  ADDR_WIDTH  line address
- mem_req_data  in  DATA_WIDTH  write data
- mem_req_tag  in  TAG_WIDTH  request tag
- mem_req_ready  out  1  request accepted when valid && ready
- mem_rsp_valid  out  1  read response valid
- mem_rsp_data  out  DATA_WIDTH  read data
- mem_rsp_tag  out  TAG_WIDTH  tag of the originating read
- mem_rsp_ready  in  1  response consumed when valid && ready

Behaviour:
- Reset (asynchronous, active-high):
  - mem_req_ready=1, mem_rsp_valid=0, mem_rsp_data=0, mem_rsp_tag=0.
  - Outstanding count=0; latency pipeline and FIFO emptied.
  - Line store contents are NOT reset; they are undefined at power-up.
- Reset mid-operation: all in-flight and queued reads are dropped, no stale response is issued after reset release, and line store contents are retained.
- Outstanding count: registered, 0..RSP_DEPTH.
  - +1 on read accept.
  - -1 on response pop.
  - Unchanged when both occur in the same cycle.
- mem_req_ready = (outstanding < RSP_DEPTH).
  - Registered state only; ready does not depend on mem_req_valid or mem_req_rw.
  - Ready gates writes as well as reads.
- Write accept: bytes with byteen[i]=1 update the line at the indexed location on the accepting edge. No response is generated.
- Read accept:
  - Line data is sampled on the accepting edge.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1.
  - Data and tag enter a non-stallable LATENCY-stage pipeline.
- Pipeline exit writes into the response FIFO, which has RSP_DEPTH entries. The credit scheme guarantees the FIFO cannot overflow; a write into a full FIFO is an assertion failure in simulation.
- Response timing and ordering:
  - With the FIFO empty and mem_rsp_ready=1, a read accepted at edge E0 presents mem_rsp_valid exactly LATENCY cycles after E0.
  - Responses are returned strictly in acceptance order.
- Response output: mem_rsp_valid = FIFO not empty. data and tag come from the FIFO head and are held stable while valid && !ready.
- Pointer wrap: FIFO pointers are log2(RSP_DEPTH)+1 bits. Full and empty are distinguished by the MSB.
- Simultaneous FIFO push and pop when full or empty: both are honoured; count is unchanged, or pass-through occurs after one registered cycle.
- Back-to-back throughput: one request per cycle sustained, and one response per cycle sustained.

Optional Feature:
- Macro: VX_MEM_RSP_PERF_EN.
- Defined: adds three output ports, each 32 bits, reset to 0, wrapping modulo 2^32:
  - perf_reads: accepted reads.
  - perf_writes: accepted writes.
  - perf_stalls: cycles with mem_req_valid && !mem_req_ready.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Write addr 0x10, data all-0xA5, byteen all-ones; next cycle read 0x10, tag 0x0005 -> mem_rsp_valid exactly 4 cycles after the read accept, data all-0xA5, tag 0x0005.
- Write 0x20 all-0xFF; then write 0x20 data 0, byteen 0x...000F; read 0x20 -> bytes 0-3 = 0x00, bytes 4-63 = 0xFF.
- mem_rsp_ready=0, issue reads tags 0..9 back-to-back:
  - ready drops after the 8th accept; tags 8 and 9 are held.
  - Raise rsp_ready -> tags 0..7 return in order.
  - ready reasserts the cycle after the first pop; tags 8 and 9 then complete.
- Outstanding=7; a read accept and a response pop in the same cycle -> count stays 7 and ready stays 1; a further accept -> ready=0.
- Write 0x3 data 0x1234 pattern; read 0x3 + 2^MEM_ADDR_BITS (0x403) -> returns the same pattern (aliasing).
- 3 reads outstanding, assert reset for 1 cycle -> rsp_valid=0 and ready=1 immediately, no responses afterward; rereading earlier written data returns the retained contents. With VX_MEM_RSP_PERF_EN, all perf counters read 0 after reset.

Source files
------------

// File: rtl/vx_mem_responder_if.sv
// Vortex external memory bus: line-granular requests in, in-order read responses out.
// master = Vortex side, slave = memory responder side.
interface vx_mem_responder_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 16
);
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [DATA_WIDTH/8-1:0] mem_req_byteen;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic                    mem_req_ready;
    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                    mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_responder.sv
// Memory-side responder: byte-enabled line store, fixed-latency read pipeline, credit-limited response FIFO.
// Optional VX_MEM_RSP_PERF_EN adds perf_reads / perf_writes / perf_stalls counters.
module vx_mem_responder #(
    parameter int DATA_WIDTH    = 512,
    parameter int ADDR_WIDTH    = 26,
    parameter int TAG_WIDTH     = 16,
    parameter int MEM_ADDR_BITS = 10,
    parameter int LATENCY       = 4,
    parameter int RSP_DEPTH     = 8
) (
    input  logic              clk,
    input  logic              reset,
    vx_mem_responder_if.slave mem
`ifdef VX_MEM_RSP_PERF_EN
    ,
    output logic [31:0]       perf_reads,
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_stalls
`endif
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshakes: a beat transfers on a rising edge where valid && ready; the
    // source holds payload stable while valid && !ready; ready never looks at valid.
    logic                     req_ready;
    logic                     req_fire;
    logic                     rd_fire;
    logic                     wr_fire;
    logic                     rsp_pop;
    logic                     fifo_push;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         outstanding;
    logic [MEM_ADDR_BITS-1:0] line_idx;

    assign req_ready = (outstanding < CNT_W'(RSP_DEPTH));
    assign req_fire  = mem.mem_req_valid && req_ready && !reset;
    assign rd_fire   = req_fire && !mem.mem_req_rw;
    assign wr_fire   = req_fire && mem.mem_req_rw;
    assign line_idx  = mem.mem_req_addr[MEM_ADDR_BITS-1:0];

    generate
        if (ADDR_WIDTH > MEM_ADDR_BITS) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem.mem_req_addr[ADDR_WIDTH-1:MEM_ADDR_BITS];
        end
    endgenerate

    // Line store is deliberately not reset so contents survive a mid-run reset.
    logic [DATA_WIDTH-1:0] line_mem [2**MEM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (mem.mem_req_byteen[i]) begin
                    line_mem[line_idx][i*8 +: 8] <= mem.mem_req_data[i*8 +: 8];
                end
            end
        end
    end

    // Non-stallable read pipeline; the credit count guarantees room at its exit.
    logic [LATENCY-1:0]    pipe_valid;
    logic [DATA_WIDTH-1:0] pipe_data [LATENCY];
    logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= rd_fire;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= line_mem[line_idx];
        pipe_tag[0]  <= mem.mem_req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
            pipe_tag[i]  <= pipe_tag[i-1];
        end
    end

    assign fifo_push = pipe_valid[LATENCY-1];

    // Response FIFO; the extra pointer MSB separates full from empty.
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_DEPTH];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rsp_pop    = !fifo_empty && mem.mem_rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (rsp_pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr[PTR_W-1:0]] <= pipe_data[LATENCY-1];
            fifo_tag[wr_ptr[PTR_W-1:0]]  <= pipe_tag[LATENCY-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_fire, rsp_pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Payload reads as zero whenever no response is presented (covers reset).
    assign mem.mem_req_ready = req_ready;
    assign mem.mem_rsp_valid = !fifo_empty;
    assign mem.mem_rsp_data  = fifo_empty ? '0 : fifo_data[rd_ptr[PTR_W-1:0]];
    assign mem.mem_rsp_tag   = fifo_empty ? '0 : fifo_tag[rd_ptr[PTR_W-1:0]];

`ifndef SYNTHESIS
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !rsp_pop));
`endif

`ifdef VX_MEM_RSP_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (rd_fire) perf_reads  <= perf_reads + 32'd1;
            if (wr_fire) perf_writes <= perf_writes + 32'd1;
            if (mem.mem_req_valid && !req_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: latency, byte enables, backpressure, credits, aliasing, reset.
module tb_vx_mem_responder;
    localparam int DW = 512;
    localparam int AW = 26;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [TW+DW-1:0] exp_q [$];

    localparam logic [DW-1:0] DATA_A5 = {64{8'hA5}};
    localparam logic [DW-1:0] DATA_FF = {64{8'hFF}};
    localparam logic [DW-1:0] DATA_BE = {{60{8'hFF}}, 32'h0};
    localparam logic [DW-1:0] DATA_12 = {32{16'h1234}};
    localparam logic [63:0]   BE_ALL  = {64{1'b1}};

    vx_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

`ifdef VX_MEM_RSP_PERF_EN
    logic [31:0] perf_reads;
    logic [31:0] perf_writes;
    logic [31:0] perf_stalls;
`endif

    vx_mem_responder dut (
        .clk   (clk),
        .reset (reset),
        .mem   (bus.slave)
`ifdef VX_MEM_RSP_PERF_EN
        ,
        .perf_reads  (perf_reads),
        .perf_writes (perf_writes),
        .perf_stalls (perf_stalls)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [63:0] be);
        check("wr_ready", bus.mem_req_ready, 1'b1);
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_rw     = 1'b1;
        bus.mem_req_addr   = addr;
        bus.mem_req_data   = data;
        bus.mem_req_byteen = be;
        tick();
        bus.mem_req_valid  = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [TW-1:0] tag, input logic [DW-1:0] exp_data);
        check("rd_ready", bus.mem_req_ready, 1'b1);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = addr;
        bus.mem_req_tag   = tag;
        exp_q.push_back({tag, exp_data});
        tick();
        bus.mem_req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("drain_pending", exp_q.size(), 0);
    endtask

    // scoreboard: every consumed response must match the oldest expectation
    always @(negedge clk) begin
        logic [TW+DW-1:0] e;
        if (!reset && bus.mem_rsp_valid && bus.mem_rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_spurious", bus.mem_rsp_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_tag", bus.mem_rsp_tag, e[TW+DW-1:DW]);
                check("rsp_data", bus.mem_rsp_data, e[DW-1:0]);
            end
        end
    end

    initial begin
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_rw     = 1'b0;
        bus.mem_req_byteen = '0;
        bus.mem_req_addr   = '0;
        bus.mem_req_data   = '0;
        bus.mem_req_tag    = '0;
        bus.mem_rsp_ready  = 1'b1;

        // reset state
        #12;
        check("rst_req_ready", bus.mem_req_ready, 1'b1);
        check("rst_rsp_valid", bus.mem_rsp_valid, 1'b0);
        check("rst_rsp_data", bus.mem_rsp_data, '0);
        check("rst_rsp_tag", bus.mem_rsp_tag, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // write then read next cycle; response exactly 4 cycles after accept
        do_write(26'h10, DATA_A5, BE_ALL);
        do_read(26'h10, 16'h0005, DATA_A5);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("lat_early_valid", bus.mem_rsp_valid, 1'b0);
        end
        tick();
        check("lat_valid", bus.mem_rsp_valid, 1'b1);
        check("lat_tag", bus.mem_rsp_tag, 16'h0005);
        check("lat_data", bus.mem_rsp_data, DATA_A5);
        wait_drain();

        // partial byte-enable write
        do_write(26'h20, DATA_FF, BE_ALL);
        do_write(26'h20, '0, 64'h000F);
        do_read(26'h20, 16'h0021, DATA_BE);
        wait_drain();

        // aliasing above MEM_ADDR_BITS
        do_write(26'h3, DATA_12, BE_ALL);
        do_read(26'h403, 16'h0403, DATA_12);
        wait_drain();

        // backpressure: ten reads with responses blocked
        bus.mem_rsp_ready = 1'b0;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 26'h10;
        for (int t = 0; t < 8; t++) begin
            bus.mem_req_tag = 16'(t);
            check("bp_ready_pre", bus.mem_req_ready, 1'b1);
            exp_q.push_back({16'(t), DATA_A5});
            tick();
        end
        check("bp_ready_drop", bus.mem_req_ready, 1'b0);
        bus.mem_req_tag = 16'd8;
        repeat (8) tick();
        check("bp_ready_held", bus.mem_req_ready, 1'b0);
        check("bp_rsp_valid", bus.mem_rsp_valid, 1'b1);
        check("bp_head_tag", bus.mem_rsp_tag, 16'd0);
        bus.mem_rsp_ready = 1'b1;
        tick();
        check("bp_ready_back", bus.mem_req_ready, 1'b1);
        exp_q.push_back({16'd8, DATA_A5});
        tick();
        bus.mem_req_tag = 16'd9;
        check("bp_ready_t9", bus.mem_req_ready, 1'b1);
        exp_q.push_back({16'd9, DATA_A5});
        tick();
        bus.mem_req_valid = 1'b0;
        wait_drain();

        // credit boundary: 7 outstanding, accept and pop together
        bus.mem_rsp_ready = 1'b0;
        for (int t = 0; t < 7; t++) do_read(26'h20, 16'(16'h40 + t), DATA_BE);
        repeat (6) tick();
        check("cr_ready_at7", bus.mem_req_ready, 1'b1);
        bus.mem_rsp_ready = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_req_rw    = 1'b0;
        bus.mem_req_addr  = 26'h20;
        bus.mem_req_tag   = 16'h47;
        exp_q.push_back({16'h47, DATA_BE});
        tick();
        bus.mem_rsp_ready = 1'b0;
        bus.mem_req_valid = 1'b0;
        check("cr_ready_same", bus.mem_req_ready, 1'b1);
        do_read(26'h20, 16'h48, DATA_BE);
        check("cr_ready_full", bus.mem_req_ready, 1'b0);
        bus.mem_rsp_ready = 1'b1;
        wait_drain();
        check("cr_ready_idle", bus.mem_req_ready, 1'b1);

        // reset with three reads in flight
        do_read(26'h10, 16'h60, DATA_A5);
        do_read(26'h10, 16'h61, DATA_A5);
        do_read(26'h10, 16'h62, DATA_A5);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("mr_rsp_valid", bus.mem_rsp_valid, 1'b0);
        check("mr_req_ready", bus.mem_req_ready, 1'b1);
        check("mr_rsp_tag", bus.mem_rsp_tag, '0);
`ifdef VX_MEM_RSP_PERF_EN
        check("mr_perf_reads", perf_reads, '0);
        check("mr_perf_writes", perf_writes, '0);
        check("mr_perf_stalls", perf_stalls, '0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) tick();
        check("mr_no_stale", bus.mem_rsp_valid, 1'b0);
        do_read(26'h10, 16'h70, DATA_A5);
        do_read(26'h20, 16'h71, DATA_BE);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
